// File: rtl/dvp_pixel_transmitter.sv
// rtl/dvp_pixel_transmitter.sv - RGB565 pixel stream to DVP byte stream with VSYNC/HREF timing
module dvp_pixel_transmitter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_PIXEL_DATA_WIDTH = 16,
    parameter int C_H_ACTIVE         = 640,
    parameter int C_H_BLANK          = 144,
    parameter int C_V_SYNC           = 3,
    parameter int C_V_BACK           = 17,
    parameter int C_V_ACTIVE         = 480,
    parameter int C_V_FRONT          = 10
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] register_control,
    input  logic [C_PIXEL_DATA_WIDTH-1:0] pixel_data,
    input  logic                          pixel_valid,
    output logic                          pixel_ready,
    output logic [7:0]                    dvp_data,
    output logic                          dvp_href,
    output logic                          dvp_vsync,
    output logic                          frame_done,
    output logic                          underrun
);

    localparam int L     = 2 * C_H_ACTIVE + C_H_BLANK;
    localparam int HW    = (L > 1) ? $clog2(L) : 1;
    localparam int VMAX1 = (C_V_SYNC > C_V_BACK) ? C_V_SYNC : C_V_BACK;
    localparam int VMAX2 = (C_V_ACTIVE > C_V_FRONT) ? C_V_ACTIVE : C_V_FRONT;
    localparam int VMAX  = (VMAX1 > VMAX2) ? VMAX1 : VMAX2;
    localparam int VW    = (VMAX > 1) ? $clog2(VMAX) : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(2 * C_H_ACTIVE);
    localparam logic [VW-1:0] VS_LAST   = VW'(C_V_SYNC - 1);
    localparam logic [VW-1:0] VB_LAST   = VW'(C_V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST   = VW'(C_V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST   = VW'(C_V_FRONT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [HW-1:0]           h_cnt, h_nxt;
    logic [VW-1:0]           v_cnt, v_nxt;
    logic [VW-1:0]           v_last;
    logic                    line_end;

    logic [C_PIXEL_DATA_WIDTH-1:0] hold_data;
    logic                          hold_full;
    logic                          starved;

    logic       enable;
    logic       underrun_clr;
    logic       active_slot, even_slot, starve_now, send_low, accept;
    logic [7:0] data_nxt;
    logic       href_nxt, vsync_nxt, fd_nxt;

    logic unused_ctrl_bits;

    assign enable           = register_control[0];
    assign underrun_clr     = register_control[1];
    assign unused_ctrl_bits = ^register_control[C_S_AXI_DATA_WIDTH-1:2];

    // State and line/pixel counters
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Next state: each vertical region lasts its line count, stepping at end of line
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        line_end  = (h_cnt == H_LAST);
        v_last    = VS_LAST;
        case (state)
            ST_VSYNC:  v_last = VS_LAST;
            ST_VBACK:  v_last = VB_LAST;
            ST_ACTIVE: v_last = VA_LAST;
            ST_VFRONT: v_last = VF_LAST;
            default:   v_last = VS_LAST;
        endcase
        if (state == ST_IDLE) begin
            if (enable) begin
                state_nxt = ST_VSYNC;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        end else begin
            h_nxt = line_end ? '0 : h_cnt + 1'b1;
            if (line_end) begin
                if (v_cnt == v_last) begin
                    v_nxt = '0;
                    case (state)
                        ST_VSYNC:  state_nxt = ST_VBACK;
                        ST_VBACK:  state_nxt = ST_ACTIVE;
                        ST_ACTIVE: state_nxt = ST_VFRONT;
                        ST_VFRONT: state_nxt = enable ? ST_VSYNC : ST_IDLE;
                        default:   state_nxt = ST_IDLE;
                    endcase
                end else begin
                    v_nxt = v_cnt + 1'b1;
                end
            end
        end
    end

    // Output decode: byte selection, starvation detection and source handshake
    always_comb begin
        active_slot = (state == ST_ACTIVE) && (h_cnt < H_ACT_END);
        even_slot   = active_slot && !h_cnt[0];
        starve_now  = even_slot && !hold_full;
        send_low    = active_slot && h_cnt[0] && !starved && hold_full;
        pixel_ready = (state != ST_IDLE) && (!hold_full || send_low);
        accept      = pixel_valid && pixel_ready;
        data_nxt    = 8'h00;
        if (even_slot && hold_full) begin
            data_nxt = hold_data[C_PIXEL_DATA_WIDTH-1 -: 8];
        end else if (send_low) begin
            data_nxt = hold_data[7:0];
        end
        href_nxt  = active_slot;
        vsync_nxt = (state == ST_VSYNC);
        fd_nxt    = (state == ST_VFRONT) && line_end && (v_cnt == VF_LAST);
    end

    // Registered outputs, holding register and sticky underrun
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            dvp_data   <= 8'h00;
            dvp_href   <= 1'b0;
            dvp_vsync  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            starved    <= 1'b0;
        end else begin
            dvp_data   <= data_nxt;
            dvp_href   <= href_nxt;
            dvp_vsync  <= vsync_nxt;
            frame_done <= fd_nxt;
            starved    <= starve_now;
            if (starve_now) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            if (accept) begin
                hold_data <= pixel_data;
                hold_full <= 1'b1;
            end else if (send_low) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule
